// File: rtl/cylon_word_sequencer_pkg.sv
// Shared definitions for the cylon word sequencer: sequencer state encoding
// and the width of a channel index.
package cylon_word_sequencer_pkg;

    localparam int CH_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN_FWD = 2'd1,
        ST_RUN_REV = 2'd2
    } seq_state_e;

endpackage

// File: rtl/cylon_word_sequencer_dwell_step_timer.sv
// Dwell timer: counts word cycles while running and flags the cycle on which
// the current step has lasted dwell+1 cycles.
module dwell_step_timer #(
    parameter int DWELL_WIDTH = 23
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic                   step
);

    logic [DWELL_WIDTH-1:0] counter_q;
    logic [DWELL_WIDTH-1:0] counter_d;

    // Live dwell compare, so shortening dwell mid-step forces the next step at once
    always_comb begin
        step = run && (counter_q >= dwell);
    end

    // Counter clears when idle or on a step, otherwise counts up
    always_comb begin
        counter_d = counter_q;
        if (!run) begin
            counter_d = '0;
        end else if (step) begin
            counter_d = '0;
        end else begin
            counter_d = counter_q + DWELL_WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_d;
        end
    end

endmodule

// File: rtl/cylon_word_sequencer.sv
// Cylon word sequencer: walks a single lit channel across the OSERDES channel
// words in wrap or bounce mode, with a sync word at each arrival at channel 0.
module cylon_word_sequencer
    import cylon_word_sequencer_pkg::*;
#(
    parameter int NUMBER_OF_CHANNELS = 12,
    parameter int WORD_WIDTH         = 8,
    parameter int DWELL_WIDTH        = 23
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    input  logic                                     enable,
    input  logic                                     bounce,
    input  logic [DWELL_WIDTH-1:0]                   dwell,
    input  logic [WORD_WIDTH-1:0]                    pulse_word,
    output logic [NUMBER_OF_CHANNELS*WORD_WIDTH-1:0] words_out,
    output logic [WORD_WIDTH-1:0]                    sync_word_out,
    output logic [CH_IDX_W-1:0]                      position,
    output logic                                     direction,
    output logic                                     step_strobe
);

    localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(NUMBER_OF_CHANNELS - 1);

    seq_state_e                              state_q, state_d;
    logic [CH_IDX_W-1:0]                     position_q, position_d;
    logic [NUMBER_OF_CHANNELS*WORD_WIDTH-1:0] words_q, words_d;
    logic [WORD_WIDTH-1:0]                   sync_q, sync_d;
    logic                                    strobe_q, strobe_d;
    logic                                    direction_q, direction_d;
    logic                                    run_s;
    logic                                    step_s;
    logic                                    active_d_s;

    assign run_s = enable && (state_q != ST_IDLE);

    dwell_step_timer #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (run_s),
        .dwell   (dwell),
        .step    (step_s)
    );

    // Next state and position, including the IDLE start and end-of-sweep turns
    always_comb begin
        state_d    = state_q;
        position_d = position_q;
        strobe_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                position_d = '0;
                if (enable) begin
                    state_d  = ST_RUN_FWD;
                    strobe_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN_FWD: begin
                if (!enable) begin
                    state_d    = ST_IDLE;
                    position_d = '0;
                end else if (step_s) begin
                    strobe_d = 1'b1;
                    if (NUMBER_OF_CHANNELS == 1) begin
                        position_d = '0;
                    end else if (position_q < LAST_CH) begin
                        position_d = position_q + CH_IDX_W'(1);
                    end else if (bounce) begin
                        state_d    = ST_RUN_REV;
                        position_d = LAST_CH - CH_IDX_W'(1);
                    end else begin
                        position_d = '0;
                    end
                end else begin
                    state_d = ST_RUN_FWD;
                end
            end
            ST_RUN_REV: begin
                if (!enable) begin
                    state_d    = ST_IDLE;
                    position_d = '0;
                end else if (step_s) begin
                    strobe_d = 1'b1;
                    if (position_q > CH_IDX_W'(0)) begin
                        position_d = position_q - CH_IDX_W'(1);
                    end else begin
                        state_d    = ST_RUN_FWD;
                        position_d = CH_IDX_W'(1);
                    end
                end else begin
                    state_d = ST_RUN_REV;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                position_d = '0;
            end
        endcase
    end

    // Output words are built from the next state so they line up with it
    always_comb begin
        active_d_s  = (state_d != ST_IDLE);
        direction_d = (state_d == ST_RUN_REV);
        words_d     = '0;
        for (int k = 0; k < NUMBER_OF_CHANNELS; k++) begin
            if (active_d_s && (position_d == CH_IDX_W'(k))) begin
                words_d[k*WORD_WIDTH +: WORD_WIDTH] = pulse_word;
            end else begin
                words_d[k*WORD_WIDTH +: WORD_WIDTH] = '0;
            end
        end
        if (strobe_d && (position_d == CH_IDX_W'(0))) begin
            sync_d = pulse_word;
        end else begin
            sync_d = '0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            position_q  <= '0;
            words_q     <= '0;
            sync_q      <= '0;
            strobe_q    <= 1'b0;
            direction_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            position_q  <= position_d;
            words_q     <= words_d;
            sync_q      <= sync_d;
            strobe_q    <= strobe_d;
            direction_q <= direction_d;
        end
    end

    assign words_out     = words_q;
    assign sync_word_out = sync_q;
    assign position      = position_q;
    assign direction     = direction_q;
    assign step_strobe   = strobe_q;

endmodule
